// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage : execute stage of the 5-stage MIPS pipeline.
//
// Captures the decode payload under a valid/allowin handshake, selects the two
// ALU operands from registered state only, evaluates the one-hot ALU in the
// same cycle, issues at most one data-SRAM request per load/store (even under
// backpressure) and exposes the result plus forwarding info to later stages.
//
// Ports
//   clk, resetn            : clock, asynchronous active-low reset
//   flush                  : kill EXE contents (exception/eret from writeback)
//   ds_to_es_valid/es_allowin : decode -> execute handshake
//   ds_*                   : decode payload (ALU op, operand selects, values)
//   ms_allowin/es_to_ms_valid : execute -> memory handshake
//   es_pc, es_alu_result, es_dest, es_gr_we, es_res_from_mem : registered/ALU
//                            results presented to the memory stage
//   es_fwd_dest, es_fwd_is_load : hazard/forwarding info for decode
//   data_sram_*            : data SRAM request (address = ALU result)
// -----------------------------------------------------------------------------
module exe_stage #(
    parameter int ALU_OP_W  = 16,
    parameter int GR_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 ds_to_es_valid,
    output logic                 es_allowin,
    input  logic [ALU_OP_W-1:0]  ds_alu_op,
    input  logic                 ds_src1_is_sa,
    input  logic                 ds_src1_is_pc,
    input  logic                 ds_src2_is_imm,
    input  logic                 ds_src2_is_zimm,
    input  logic                 ds_src2_is_8,
    input  logic [31:0]          ds_rs_value,
    input  logic [31:0]          ds_rt_value,
    input  logic [15:0]          ds_imm,
    input  logic [4:0]           ds_sa,
    input  logic [31:0]          ds_pc,
    input  logic [GR_ADDR_W-1:0] ds_dest,
    input  logic                 ds_gr_we,
    input  logic                 ds_mem_we,
    input  logic                 ds_res_from_mem,
    input  logic                 ms_allowin,
    output logic                 es_to_ms_valid,
    output logic [31:0]          es_pc,
    output logic [31:0]          es_alu_result,
    output logic [GR_ADDR_W-1:0] es_dest,
    output logic                 es_gr_we,
    output logic                 es_res_from_mem,
    output logic [GR_ADDR_W-1:0] es_fwd_dest,
    output logic                 es_fwd_is_load,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_wen,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata
);

    logic                 r_es_valid;
    logic                 r_mem_issued;
    logic [ALU_OP_W-1:0]  r_alu_op;
    logic                 r_src1_is_sa;
    logic                 r_src1_is_pc;
    logic                 r_src2_is_imm;
    logic                 r_src2_is_zimm;
    logic                 r_src2_is_8;
    logic [31:0]          r_rs;
    logic [31:0]          r_rt;
    logic [15:0]          r_imm;
    logic [4:0]           r_sa;
    logic [31:0]          r_pc;
    logic [GR_ADDR_W-1:0] r_dest;
    logic                 r_gr_we;
    logic                 r_mem_we;
    logic                 r_res_from_mem;

    logic        w_ready_go;
    logic        w_load;
    logic        w_sram_en;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_result;
    logic        w_op_reserved;

    // Single-cycle ALU: the stage is always ready to hand off.
    assign w_ready_go     = 1'b1;
    assign es_allowin     = !r_es_valid | (w_ready_go & ms_allowin);
    assign es_to_ms_valid = r_es_valid & w_ready_go & !flush;
    assign w_load         = ds_to_es_valid & es_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_es_valid     <= 1'b0;
            r_mem_issued   <= 1'b0;
            r_alu_op       <= '0;
            r_src1_is_sa   <= 1'b0;
            r_src1_is_pc   <= 1'b0;
            r_src2_is_imm  <= 1'b0;
            r_src2_is_zimm <= 1'b0;
            r_src2_is_8    <= 1'b0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_imm          <= '0;
            r_sa           <= '0;
            r_pc           <= '0;
            r_dest         <= '0;
            r_gr_we        <= 1'b0;
            r_mem_we       <= 1'b0;
            r_res_from_mem <= 1'b0;
        end else begin
            // Flush beats a simultaneous handshake; decode is flushed too.
            if (flush) begin
                r_es_valid <= 1'b0;
            end else if (es_allowin) begin
                r_es_valid <= ds_to_es_valid;
            end

            // Remember that this instruction already touched the SRAM so a
            // stalled load/store is not re-issued every held cycle.
            if (flush || w_load) begin
                r_mem_issued <= 1'b0;
            end else if (w_sram_en && !ms_allowin) begin
                r_mem_issued <= 1'b1;
            end

            if (w_load) begin
                r_alu_op       <= ds_alu_op;
                r_src1_is_sa   <= ds_src1_is_sa;
                r_src1_is_pc   <= ds_src1_is_pc;
                r_src2_is_imm  <= ds_src2_is_imm;
                r_src2_is_zimm <= ds_src2_is_zimm;
                r_src2_is_8    <= ds_src2_is_8;
                r_rs           <= ds_rs_value;
                r_rt           <= ds_rt_value;
                r_imm          <= ds_imm;
                r_sa           <= ds_sa;
                r_pc           <= ds_pc;
                r_dest         <= ds_dest;
                r_gr_we        <= ds_gr_we;
                r_mem_we       <= ds_mem_we;
                r_res_from_mem <= ds_res_from_mem;
            end
        end
    end

    // Operand selection from registered flags only.
    always_comb begin
        w_src1 = r_rs;
        if (r_src1_is_sa) begin
            w_src1 = {27'b0, r_sa};
        end else if (r_src1_is_pc) begin
            w_src1 = r_pc;
        end

        w_src2 = r_rt;
        if (r_src2_is_imm) begin
            w_src2 = {{16{r_imm[15]}}, r_imm};
        end else if (r_src2_is_zimm) begin
            w_src2 = {16'b0, r_imm};
        end else if (r_src2_is_8) begin
            w_src2 = 32'd8;
        end
    end

    // One-hot ALU: each op bit gates its own result onto an OR bus.
    assign w_result =
          ({32{r_alu_op[0]}}  & (w_src1 + w_src2))
        | ({32{r_alu_op[1]}}  & (w_src1 - w_src2))
        | ({32{r_alu_op[2]}}  & {31'b0, $signed(w_src1) < $signed(w_src2)})
        | ({32{r_alu_op[3]}}  & {31'b0, w_src1 < w_src2})
        | ({32{r_alu_op[4]}}  & (w_src1 & w_src2))
        | ({32{r_alu_op[5]}}  & ~(w_src1 | w_src2))
        | ({32{r_alu_op[6]}}  & (w_src1 | w_src2))
        | ({32{r_alu_op[7]}}  & (w_src1 ^ w_src2))
        | ({32{r_alu_op[8]}}  & (w_src2 << w_src1[4:0]))
        | ({32{r_alu_op[9]}}  & (w_src2 >> w_src1[4:0]))
        | ({32{r_alu_op[10]}} & 32'($signed(w_src2) >>> w_src1[4:0]))
        | ({32{r_alu_op[11]}} & {w_src2[15:0], 16'b0});

    // Reserved op bits carry no operation; force a clean zero if ever set.
    assign w_op_reserved = |r_alu_op[ALU_OP_W-1:12];
    assign es_alu_result = w_op_reserved ? 32'b0 : w_result;

    assign es_pc           = r_pc;
    assign es_dest         = r_dest;
    assign es_gr_we        = r_gr_we;
    assign es_res_from_mem = r_res_from_mem;

    assign es_fwd_dest    = (r_es_valid & r_gr_we) ? r_dest : '0;
    assign es_fwd_is_load = r_es_valid & r_res_from_mem;

    assign w_sram_en       = r_es_valid & (r_mem_we | r_res_from_mem) & !r_mem_issued & !flush;
    assign data_sram_en    = w_sram_en;
    assign data_sram_wen   = w_sram_en ? {4{r_mem_we}} : 4'b0;
    assign data_sram_addr  = es_alu_result;
    assign data_sram_wdata = r_rt;

endmodule

// File: tb/tb_exe_stage.sv
`timescale 1ns/1ps
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        ds_to_es_valid = 1'b0;
    logic        es_allowin;
    logic [15:0] ds_alu_op = '0;
    logic        ds_src1_is_sa = 1'b0, ds_src1_is_pc = 1'b0;
    logic        ds_src2_is_imm = 1'b0, ds_src2_is_zimm = 1'b0, ds_src2_is_8 = 1'b0;
    logic [31:0] ds_rs_value = '0, ds_rt_value = '0, ds_pc = '0;
    logic [15:0] ds_imm = '0;
    logic [4:0]  ds_sa = '0, ds_dest = '0;
    logic        ds_gr_we = 1'b0, ds_mem_we = 1'b0, ds_res_from_mem = 1'b0;
    logic        ms_allowin = 1'b0;
    logic        es_to_ms_valid;
    logic [31:0] es_pc, es_alu_result;
    logic [4:0]  es_dest, es_fwd_dest;
    logic        es_gr_we, es_res_from_mem, es_fwd_is_load;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;

    exe_stage #(.ALU_OP_W(16), .GR_ADDR_W(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_alu_op(ds_alu_op),
        .ds_src1_is_sa(ds_src1_is_sa), .ds_src1_is_pc(ds_src1_is_pc),
        .ds_src2_is_imm(ds_src2_is_imm), .ds_src2_is_zimm(ds_src2_is_zimm),
        .ds_src2_is_8(ds_src2_is_8),
        .ds_rs_value(ds_rs_value), .ds_rt_value(ds_rt_value),
        .ds_imm(ds_imm), .ds_sa(ds_sa), .ds_pc(ds_pc), .ds_dest(ds_dest),
        .ds_gr_we(ds_gr_we), .ds_mem_we(ds_mem_we), .ds_res_from_mem(ds_res_from_mem),
        .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_pc(es_pc), .es_alu_result(es_alu_result), .es_dest(es_dest),
        .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem),
        .es_fwd_dest(es_fwd_dest), .es_fwd_is_load(es_fwd_is_load),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    always #5 clk = ~clk;

    // Op indices: 0 add 1 sub 2 slt 3 sltu 4 and 5 nor 6 or 7 xor
    //             8 sll 9 srl 10 sra 11 lui
    typedef struct {
        int          op;
        bit          sa_f, pc_f, imm_f, zimm_f, f8;
        logic [31:0] rs, rt, pc;
        logic [15:0] imm;
        logic [4:0]  sa, dest;
        bit          gr_we, st, ld;
    } ds_t;

    typedef struct {
        logic [31:0] pc, res, wdata;
        logic [4:0]  dest;
        bit          gr_we, ld, st, issued;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %08h required %08h", name, act, req);
    endtask

    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << sh;
            9:  return b >> sh;
            10: return 32'(signed'(b) >>> sh);
            11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t model(ds_t d);
        exp_t e;
        logic [31:0] a, b;
        if (d.sa_f)        a = 32'(d.sa);
        else if (d.pc_f)   a = d.pc;
        else               a = d.rs;
        if (d.imm_f)       b = 32'(signed'(d.imm));
        else if (d.zimm_f) b = 32'(d.imm);
        else if (d.f8)     b = 32'd8;
        else               b = d.rt;
        e.pc = d.pc; e.res = ref_alu(d.op, a, b); e.wdata = d.rt;
        e.dest = d.dest; e.gr_we = d.gr_we; e.ld = d.ld; e.st = d.st;
        e.issued = 1'b0;
        return e;
    endfunction

    // One cycle of stimulus; the accepted payload's expectation is queued.
    task automatic drive(ds_t d, bit v, bit ms, bit fl);
        @(posedge clk); #1;
        ds_to_es_valid = v; ms_allowin = ms; flush = fl;
        ds_alu_op = 16'h1 << d.op;
        ds_src1_is_sa = d.sa_f; ds_src1_is_pc = d.pc_f;
        ds_src2_is_imm = d.imm_f; ds_src2_is_zimm = d.zimm_f; ds_src2_is_8 = d.f8;
        ds_rs_value = d.rs; ds_rt_value = d.rt; ds_pc = d.pc; ds_imm = d.imm;
        ds_sa = d.sa; ds_dest = d.dest; ds_gr_we = d.gr_we;
        ds_mem_we = d.st; ds_res_from_mem = d.ld;
        @(negedge clk); #1;
        if (resetn && v && !fl && es_allowin) q.push_back(model(d));
    endtask

    function automatic ds_t rand_ds();
        ds_t d;
        int m;
        d.op = $urandom_range(0, 11);
        d.sa_f = ($urandom % 5) == 0; d.pc_f = ($urandom % 5) == 0;
        d.imm_f = ($urandom % 4) == 0; d.zimm_f = ($urandom % 4) == 0;
        d.f8 = ($urandom % 5) == 0;
        d.rs = $urandom; d.rt = $urandom; d.pc = $urandom;
        d.imm = 16'($urandom); d.sa = 5'($urandom); d.dest = 5'($urandom);
        d.gr_we = $urandom % 2;
        m = $urandom % 6;
        d.st = (m == 0); d.ld = (m == 1);
        return d;
    endfunction

    // Monitor / scoreboard: q[0] is what the model says EXE holds this cycle.
    always @(negedge clk) begin
        if (resetn) begin
            exp_t e;
            bit   have, en_exp;
            have   = q.size() != 0;
            en_exp = 1'b0;
            check("to_ms_valid", 32'(es_to_ms_valid), 32'(have && !flush));
            check("allowin", 32'(es_allowin), 32'(!have || ms_allowin));
            if (have) begin
                e = q[0];
                en_exp = (e.ld || e.st) && !e.issued && !flush;
                check("fwd_dest", 32'(es_fwd_dest), e.gr_we ? 32'(e.dest) : 32'd0);
                check("fwd_is_load", 32'(es_fwd_is_load), 32'(e.ld));
            end else begin
                check("fwd_dest", 32'(es_fwd_dest), 32'd0);
                check("fwd_is_load", 32'(es_fwd_is_load), 32'd0);
            end
            check("sram_en", 32'(data_sram_en), 32'(en_exp));
            check("sram_wen", 32'(data_sram_wen), (en_exp && e.st) ? 32'hF : 32'h0);
            if (en_exp) begin
                check("sram_addr", data_sram_addr, e.res);
                check("sram_wdata", data_sram_wdata, e.wdata);
                e.issued = 1'b1;
                q[0] = e;
            end
            if (have && !flush) begin
                check("alu_result", es_alu_result, e.res);
                check("es_pc", es_pc, e.pc);
                check("es_dest", 32'(es_dest), 32'(e.dest));
                check("es_gr_we", 32'(es_gr_we), 32'(e.gr_we));
                check("es_res_from_mem", 32'(es_res_from_mem), 32'(e.ld));
                if (ms_allowin) void'(q.pop_front());
            end
            if (have && flush) q.delete();
        end
    end

    ds_t idle, d;

    task automatic idle_cycle(bit ms);
        drive(idle, 1'b0, ms, 1'b0);
    endtask

    initial begin
        idle = '{op:0, default:'0};

        // Reset state
        @(posedge clk); #3;
        check("rst_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        check("rst_sram_en", 32'(data_sram_en), 32'd0);
        check("rst_alu_result", es_alu_result, 32'd0);
        check("rst_fwd_dest", 32'(es_fwd_dest), 32'd0);
        @(negedge clk); resetn = 1'b1;

        // addiu rs=5, imm=0xFFFF -> 4
        d = idle; d.op = 0; d.imm_f = 1; d.rs = 32'h5; d.imm = 16'hFFFF; d.dest = 5'd7; d.gr_we = 1;
        drive(d, 1'b1, 1'b1, 1'b0);
        idle_cycle(1'b1);
        check("addiu_result", es_alu_result, 32'h0000_0004);

        // sll sa=4, rt=0xF -> 0xF0
        d = idle; d.op = 8; d.sa_f = 1; d.sa = 5'd4; d.rt = 32'hF; d.dest = 5'd3; d.gr_we = 1;
        drive(d, 1'b1, 1'b1, 1'b0);
        idle_cycle(1'b1);
        check("sll_result", es_alu_result, 32'h0000_00F0);

        // lui imm=0x1234
        d = idle; d.op = 11; d.imm_f = 1; d.imm = 16'h1234; d.dest = 5'd9; d.gr_we = 1;
        drive(d, 1'b1, 1'b1, 1'b0);
        idle_cycle(1'b1);
        check("lui_result", es_alu_result, 32'h1234_0000);

        // jal link: pc + 8
        d = idle; d.op = 0; d.pc_f = 1; d.f8 = 1; d.pc = 32'hBFC0_0010; d.dest = 5'd31; d.gr_we = 1;
        drive(d, 1'b1, 1'b1, 1'b0);
        idle_cycle(1'b1);
        check("jal_result", es_alu_result, 32'hBFC0_0018);

        // sw held for 3 cycles: exactly one request
        d = idle; d.op = 0; d.imm_f = 1; d.rs = 32'h1000; d.imm = 16'h4; d.rt = 32'hDEAD_BEEF; d.st = 1;
        drive(d, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("sw_en", 32'(data_sram_en), 32'd1);
        check("sw_wen", 32'(data_sram_wen), 32'hF);
        check("sw_addr", data_sram_addr, 32'h0000_1004);
        check("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
        idle_cycle(1'b0);
        check("sw_no_reissue", 32'(data_sram_en), 32'd0);
        check("sw_held_allowin", 32'(es_allowin), 32'd0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // lw in EXE, then flush together with a new valid payload
        d = idle; d.op = 0; d.imm_f = 1; d.rs = 32'h2000; d.ld = 1; d.dest = 5'd5; d.gr_we = 1;
        drive(d, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("lw_fwd_is_load", 32'(es_fwd_is_load), 32'd1);
        d.dest = 5'd6;
        drive(d, 1'b1, 1'b0, 1'b1);
        idle_cycle(1'b1);
        check("flush_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        check("flush_sram_en", 32'(data_sram_en), 32'd0);
        check("flush_fwd_dest", 32'(es_fwd_dest), 32'd0);

        // Asynchronous reset while a store is stalled
        d = idle; d.op = 0; d.imm_f = 1; d.rs = 32'h3000; d.rt = 32'h1234_5678; d.st = 1;
        d.pc = 32'hBFC0_0100; d.dest = 5'd2; d.gr_we = 1;
        drive(d, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("arst_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        check("arst_sram_en", 32'(data_sram_en), 32'd0);
        check("arst_es_pc", es_pc, 32'd0);
        check("arst_fwd_dest", 32'(es_fwd_dest), 32'd0);
        check("arst_alu_result", es_alu_result, 32'd0);
        q.delete();
        @(posedge clk); #3;
        resetn = 1'b1;
        idle_cycle(1'b0);
        check("post_rst_allowin", 32'(es_allowin), 32'd1);
        check("post_rst_sram_en", 32'(data_sram_en), 32'd0);

        // Randomized traffic with backpressure and occasional flushes
        for (int i = 0; i < 3000; i++) begin
            drive(rand_ds(), ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
        for (int i = 0; i < 4; i++) idle_cycle(1'b1);
        check("drain", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
